// File: rtl/shift_pipe_if.sv
// Valid/ready bundle for shift_pipe: producer-side operation fields and consumer-side result.
interface shift_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_type;
    logic [7:0]       in_amt;
    logic             in_imm;
    logic             in_carry;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_type, in_amt, in_imm, in_carry, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_type, in_amt, in_imm, in_carry, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_tag
    );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined ARM-style barrel shifter (LSL/LSR/ASR/ROR, immediate and register amounts)
// with exact carry-out and valid/ready handshaking; latency equals STAGES.
module shift_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic        clk,
    input  logic        rst,
    shift_pipe_if.slave bus
);
    localparam int unsigned L     = $clog2(WIDTH);
    localparam int unsigned WU    = WIDTH;
    localparam int unsigned SPLIT = (STAGES == 2) ? (L + 1) / 2 : L;
    localparam logic [7:0]   W8    = 8'(WIDTH);
    localparam logic [L-1:0] ONE_L = L'(1);

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x, input shift_t t,
                                              input int unsigned k);
        case (t)
            SH_LSL:  step = x << k;
            SH_LSR:  step = x >> k;
            SH_ASR:  step = $unsigned($signed(x) >>> k);
            default: step = (x >> k) | (x << (WU - k));
        endcase
    endfunction

    // Log-shifter levels lo..hi-1 (shift by 1, 2, 4, ... when the amount bit is set).
    function automatic logic [WIDTH-1:0] apply_range(input logic [WIDTH-1:0] x, input shift_t t,
                                                     input logic [L-1:0] amt,
                                                     input int unsigned lo, input int unsigned hi);
        logic [WIDTH-1:0] y;
        y = x;
        for (int unsigned i = lo; i < hi; i++) begin
            if (|((amt >> i) & ONE_L)) y = step(y, t, 32'd1 << i);
        end
        return y;
    endfunction

    shift_t           sh_t;
    logic             rrx;
    logic [7:0]       n;
    logic [L-1:0]     n_low;
    logic [L-1:0]     neg_idx;
    logic [L-1:0]     dec_idx;
    logic [WIDTH-1:0] f_pre;
    logic [L-1:0]     f_amt;
    logic             f_carry;
    logic [WIDTH-1:0] f_data;

    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    shift_t           m_type;
    logic [L-1:0]     m_amt;
    logic             m_carry;
    logic [TAG_W-1:0] m_tag;
    logic [WIDTH-1:0] b_data;

    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             o_carry;
    logic [TAG_W-1:0] o_tag;
    logic             out_load_ok;
    logic             in_ready_i;

    // Every case is folded into "pre-loaded operand + in-range amount + precomputed carry",
    // so the shifter core never sees an out-of-range amount.
    always_comb begin
        sh_t = shift_t'(bus.in_type);
        rrx  = 1'b0;
        n    = bus.in_amt;
        if (bus.in_imm) begin
            n = {{(8-L){1'b0}}, bus.in_amt[L-1:0]};
            if (n == '0) begin
                case (sh_t)
                    SH_LSR, SH_ASR: n = W8;
                    SH_ROR:         rrx = 1'b1;
                    default:        ;
                endcase
            end
        end
        n_low   = n[L-1:0];
        neg_idx = ~n_low + ONE_L;
        dec_idx = n_low - ONE_L;
        f_pre   = bus.in_data;
        f_amt   = '0;
        f_carry = bus.in_carry;
        if (rrx) begin
            f_pre   = {bus.in_carry, bus.in_data[WIDTH-1:1]};
            f_carry = bus.in_data[0];
        end else if (n != '0) begin
            case (sh_t)
                SH_LSL: begin
                    if (n < W8) begin
                        f_amt   = n_low;
                        f_carry = bus.in_data[neg_idx];
                    end else begin
                        f_pre   = '0;
                        f_carry = (n == W8) ? bus.in_data[0] : 1'b0;
                    end
                end
                SH_LSR: begin
                    if (n < W8) begin
                        f_amt   = n_low;
                        f_carry = bus.in_data[dec_idx];
                    end else begin
                        f_pre   = '0;
                        f_carry = (n == W8) ? bus.in_data[WIDTH-1] : 1'b0;
                    end
                end
                SH_ASR: begin
                    if (n < W8) begin
                        f_amt   = n_low;
                        f_carry = bus.in_data[dec_idx];
                    end else begin
                        f_pre   = {WIDTH{bus.in_data[WIDTH-1]}};
                        f_carry = bus.in_data[WIDTH-1];
                    end
                end
                default: begin
                    if (n_low == '0) begin
                        f_carry = bus.in_data[WIDTH-1];
                    end else begin
                        f_amt   = n_low;
                        f_carry = bus.in_data[dec_idx];
                    end
                end
            endcase
        end
        f_data = apply_range(f_pre, sh_t, f_amt, 0, SPLIT);
    end

    assign out_load_ok = !o_valid || bus.out_ready;

    generate
        if (STAGES == 2) begin : g_two
            logic             s1_valid;
            logic [WIDTH-1:0] s1_data;
            shift_t           s1_type;
            logic [L-1:0]     s1_amt;
            logic             s1_carry;
            logic [TAG_W-1:0] s1_tag;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                    s1_type  <= SH_LSL;
                    s1_amt   <= '0;
                    s1_carry <= 1'b0;
                    s1_tag   <= '0;
                end else if (in_ready_i) begin
                    s1_valid <= bus.in_valid;
                    if (bus.in_valid) begin
                        s1_data  <= f_data;
                        s1_type  <= sh_t;
                        s1_amt   <= f_amt;
                        s1_carry <= f_carry;
                        s1_tag   <= bus.in_tag;
                    end
                end
            end

            assign in_ready_i = !s1_valid || out_load_ok;
            assign m_valid    = s1_valid;
            assign m_data     = s1_data;
            assign m_type     = s1_type;
            assign m_amt      = s1_amt;
            assign m_carry    = s1_carry;
            assign m_tag      = s1_tag;
        end else begin : g_one
            assign in_ready_i = out_load_ok;
            assign m_valid    = bus.in_valid;
            assign m_data     = f_data;
            assign m_type     = sh_t;
            assign m_amt      = f_amt;
            assign m_carry    = f_carry;
            assign m_tag      = bus.in_tag;
        end
    endgenerate

    always_comb begin
        b_data = apply_range(m_data, m_type, m_amt, SPLIT, L);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_carry <= 1'b0;
            o_tag   <= '0;
        end else if (out_load_ok) begin
            o_valid <= m_valid;
            if (m_valid) begin
                o_data  <= b_data;
                o_carry <= m_carry;
                o_tag   <= m_tag;
            end
        end
    end

    assign bus.in_ready  = in_ready_i;
    assign bus.out_valid = o_valid;
    assign bus.out_data  = o_data;
    assign bus.out_carry = o_carry;
    assign bus.out_tag   = o_tag;
endmodule
